// File: rtl/serial_adder.sv
// Bit-serial 8-bit add/subtract: one full-adder cell, LSB first, 8 cycles per op.
// Optional SERIAL_ADDER_SAT_EN: saturate sum to 0x7F/0x80 on signed overflow.
module serial_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic       busy,
    output logic       done,
    output logic [7:0] sum,
    output logic       cout,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [7:0]  opa, opb, res;
    logic [2:0]  cnt;
    logic        carry, c7in;
    logic        bit_s, bit_c;
    logic [7:0]  res_next, sum_final;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bit_s    = opa[0] ^ opb[0] ^ carry;
        bit_c    = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
        res_next = {bit_s, res[7:1]};
`ifdef SERIAL_ADDER_SAT_EN
        // Overflow flips the sign bit, so the raw MSB tells which rail to clamp to.
        if (c7in ^ bit_c)
            sum_final = res_next[7] ? 8'h7F : 8'h80;
        else
            sum_final = res_next;
`else
        sum_final = res_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            c7in     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b ^ {8{cin}};
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    opa   <= {1'b0, opa[7:1]};
                    opb   <= {1'b0, opb[7:1]};
                    res   <= res_next;
                    carry <= bit_c;
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd6)
                        c7in <= bit_c;
                    if (cnt == 3'd7) begin
                        sum      <= sum_final;
                        cout     <= bit_c;
                        overflow <= c7in ^ bit_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes arithmetic-model results, monitor checks on done.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout, overflow;
    logic [7:0] sum;

    serial_adder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  s;
        logic        c;
        logic        v;
        int unsigned acc;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sub;
    } exp_t;

    exp_t        sb[$];
    int unsigned tests = 0, fails = 0;
    int unsigned cyc = 0;
    logic        rst_was_low = 1'b1;

    always @(posedge clk) begin
        cyc++;
        rst_was_low = !rst_n;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain modulo-256 arithmetic with sign-rule overflow.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic sub);
        exp_t       e;
        int         full;
        logic [7:0] r;
        full = sub ? (int'(x) - int'(y) + 256) : (int'(x) + int'(y));
        r    = full[7:0];
        e.s  = r;
        e.c  = full[8];
        e.v  = sub ? ((x[7] != y[7]) && (r[7] != x[7]))
                   : ((x[7] == y[7]) && (r[7] != x[7]));
`ifdef SERIAL_ADDER_SAT_EN
        if (e.v) e.s = r[7] ? 8'h7F : 8'h80;
`endif
        e.a = x; e.b = y; e.sub = sub; e.acc = 0;
        return e;
    endfunction

    // Monitor
    int unsigned busy_cnt = 0;
    logic [7:0]  h_sum = '0;
    logic        h_c = 1'b0, h_v = 1'b0, prev_done = 1'b0;

    always @(negedge clk) begin
        if (rst_was_low) begin
            busy_cnt  = 0;
            h_sum     = '0;
            h_c       = 1'b0;
            h_v       = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (prev_done) check("done_width", 2, 1);
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("sum %h%s%h", e.a, e.sub ? "-" : "+", e.b), sum, e.s);
                    check("cout", cout, e.c);
                    check("overflow", overflow, e.v);
                    check("latency", cyc - e.acc, 8);
                    check("busy_cycles", busy_cnt, 8);
                end
                busy_cnt = 0;
                h_sum = sum; h_c = cout; h_v = overflow;
            end else begin
                check("sum_stable", sum, h_sum);
                check("flags_stable", {cout, overflow}, {h_c, h_v});
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 1, 0);
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic sub,
                          input bit expect_done);
        exp_t e;
        wait_idle();
        a = x; b = y; cin = sub; start = 1'b1;
        @(posedge clk);
        #1;
        e     = model(x, y, sub);
        e.acc = cyc;
        if (expect_done) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {cout, overflow}, 0);
        rst_n = 1'b1;

        run_op(8'h05, 8'h03, 1'b0, 1'b1);
        run_op(8'h7F, 8'h01, 1'b0, 1'b1);
        run_op(8'h05, 8'h07, 1'b1, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b1);
        run_op(8'h80, 8'h01, 1'b1, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 1'b1);

        // Start while running must be ignored.
        run_op(8'h10, 8'h20, 1'b0, 1'b1);
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset mid-operation: no done, outputs cleared.
        run_op(8'h05, 8'h03, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_flags", {cout, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op(8'h05, 8'h03, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] x, y;
            logic       s;
            x = $urandom; y = $urandom; s = $urandom_range(0, 1);
            run_op(x, y, s, 1'b1);
        end

        begin
            int unsigned n = 0;
            while (sb.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("scoreboard_drained", sb.size(), 0);
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
